clk_div_ctrl: RTL and testbench

- Run-time controller for the system clock divider path.
- Generates a registered divided clock `clk_o` and a one-cycle `tick_o` strobe from `clk_i`.
- The divide ratio N is programmable through a valid/ready config handshake.
- Ratio changes and start/stop are sequenced so they only take effect on period boundaries. No truncated or glitched phases reach downstream logic.
- Default N=2 reproduces the existing 100 MHz to 50 MHz divide.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_ctrl.sv | 107 ++++++++++
 tb/tb_clk_div_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF,
        RUN,
        PEND
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // Ratios below DIV_MIN cannot form a valid high/low period, so they are raised to it.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with boundary-aligned ratio changes and start/stop.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] cfg_div_i,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    output logic         clk_o,
    output logic         tick_o,
    output logic [W-1:0] div_o,
    output logic         busy_o
);

    localparam logic [W-1:0] DIV_RESET = W'(DEF_DIV);
    localparam logic [W-1:0] ONE       = W'(1);

    state_e         state, state_d;
    logic [W-1:0]   cnt, cnt_d;
    logic [W-1:0]   div, div_d;
    logic [W-1:0]   pend, pend_d;
    logic           clk_d, tick_d;
    logic           accept, wrap, running_d;
    logic [W-1:0]   cfg_clamped;

    assign cfg_ready_o = (state != PEND);
    assign busy_o      = (state != OFF);
    assign div_o       = div;

    always_comb begin
        accept      = cfg_valid_i && cfg_ready_o;
        cfg_clamped = W'(clamp_div(32'(cfg_div_i)));
        wrap        = (cnt == (div - ONE));

        state_d = state;
        cnt_d   = cnt;
        div_d   = div;
        pend_d  = pend;

        unique case (state)
            OFF: begin
                cnt_d = '0;
                if (accept) begin
                    div_d = cfg_clamped;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt + ONE;
                if (accept) begin
                    // On the wrap edge the new ratio can govern the very next period directly.
                    if (wrap) begin
                        div_d = cfg_clamped;
                    end else begin
                        pend_d  = cfg_clamped;
                        state_d = PEND;
                    end
                end
                if (wrap && !en_i) begin
                    state_d = OFF;
                end
            end
            PEND: begin
                cnt_d = wrap ? '0 : cnt + ONE;
                if (wrap) begin
                    div_d   = pend;
                    state_d = en_i ? RUN : OFF;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from next-cycle state so they leave the flops glitch-free.
        running_d = (state_d != OFF);
        clk_d     = running_d && (cnt_d < (div_d >> 1));
        tick_d    = running_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= OFF;
            cnt    <= '0;
            div    <= DIV_RESET;
            pend   <= DIV_RESET;
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            div    <= div_d;
            pend   <= pend_d;
            clk_o  <= clk_d;
            tick_o <= tick_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [15:0] cfg_div_i = '0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        clk_o;
    logic        tick_o;
    logic [15:0] div_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(
        .W      (16),
        .DEF_DIV(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .clk_o      (clk_o),
        .tick_o     (tick_o),
        .div_o      (div_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Flags are {clk_o, tick_o, busy_o, cfg_ready_o}.
    task automatic chk(input string tag, input logic [3:0] f, input logic [15:0] d);
        logic [19:0] obs;
        logic [19:0] exp;
        obs = {clk_o, tick_o, busy_o, cfg_ready_o, div_o};
        exp = {f, d};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] f, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        chk(tag, f, d);
    endtask

    task automatic cfg(input logic v, input logic [15:0] n);
        cfg_valid_i = v;
        cfg_div_i   = n;
    endtask

    initial begin
        #12;
        chk("reset", 4'b0001, 16'd2);
        rst_i = 1'b0;

        // Default ratio 2
        en_i = 1'b1;
        cyc("n2_c0", 4'b1111, 16'd2);
        cyc("n2_c1", 4'b0011, 16'd2);
        cyc("n2_c0b", 4'b1111, 16'd2);
        cyc("n2_c1b", 4'b0011, 16'd2);
        en_i = 1'b0;
        cyc("n2_off", 4'b0001, 16'd2);

        // Ratio 5 written in OFF, then run
        cfg(1'b1, 16'd5);
        cyc("off_cfg5", 4'b0001, 16'd5);
        cfg(1'b0, 16'd0);
        en_i = 1'b1;
        cyc("n5_c0", 4'b1111, 16'd5);
        cyc("n5_c1", 4'b1011, 16'd5);
        cyc("n5_c2", 4'b0011, 16'd5);
        cyc("n5_c3", 4'b0011, 16'd5);
        cyc("n5_c4", 4'b0011, 16'd5);
        cyc("n5_c0b", 4'b1111, 16'd5);
        en_i = 1'b0;
        cyc("n5_stop_c1", 4'b1011, 16'd5);
        cyc("n5_stop_c2", 4'b0011, 16'd5);
        cyc("n5_stop_c3", 4'b0011, 16'd5);
        cyc("n5_stop_c4", 4'b0011, 16'd5);
        cyc("n5_off", 4'b0001, 16'd5);

        // Simultaneous config and enable in OFF, then a mid-period change 4 -> 6
        cfg(1'b1, 16'd4);
        en_i = 1'b1;
        cyc("n4_c0", 4'b1111, 16'd4);
        cfg(1'b0, 16'd0);
        cyc("n4_c1", 4'b1011, 16'd4);
        cfg(1'b1, 16'd6);
        cyc("pend_c2", 4'b0010, 16'd4);
        cfg(1'b0, 16'd0);
        cyc("pend_c3", 4'b0010, 16'd4);
        cyc("n6_c0", 4'b1111, 16'd6);
        cyc("n6_c1", 4'b1011, 16'd6);
        cyc("n6_c2", 4'b1011, 16'd6);
        cyc("n6_c3", 4'b0011, 16'd6);
        cyc("n6_c4", 4'b0011, 16'd6);
        cyc("n6_c5", 4'b0011, 16'd6);
        cyc("n6_c0b", 4'b1111, 16'd6);

        // Write 3 exactly on a wrap cycle
        cyc("w_c1", 4'b1011, 16'd6);
        cyc("w_c2", 4'b1011, 16'd6);
        cyc("w_c3", 4'b0011, 16'd6);
        cyc("w_c4", 4'b0011, 16'd6);
        cyc("w_c5", 4'b0011, 16'd6);
        cfg(1'b1, 16'd3);
        cyc("n3_c0", 4'b1111, 16'd3);
        cfg(1'b0, 16'd0);
        cyc("n3_c1", 4'b0011, 16'd3);
        cyc("n3_c2", 4'b0011, 16'd3);
        cyc("n3_c0b", 4'b1111, 16'd3);
        cyc("n3_c1b", 4'b0011, 16'd3);
        cyc("n3_c2b", 4'b0011, 16'd3);

        // Clamp: 0 on wrap, 1 via pend
        cfg(1'b1, 16'd0);
        cyc("clamp0", 4'b1111, 16'd2);
        cfg(1'b1, 16'd1);
        cyc("clamp1_pend", 4'b0010, 16'd2);
        cfg(1'b0, 16'd0);
        cyc("clamp1_c0", 4'b1111, 16'd2);
        cyc("clamp1_c1", 4'b0011, 16'd2);
        cyc("clamp1_c0b", 4'b1111, 16'd2);

        // Ratio 6, drop enable at cnt=1 and at cnt=5
        cfg(1'b1, 16'd6);
        cyc("to6_pend", 4'b0010, 16'd2);
        cfg(1'b0, 16'd0);
        cyc("s6_c0", 4'b1111, 16'd6);
        cyc("s6_c1", 4'b1011, 16'd6);
        en_i = 1'b0;
        cyc("s6_c2", 4'b1011, 16'd6);
        cyc("s6_c3", 4'b0011, 16'd6);
        cyc("s6_c4", 4'b0011, 16'd6);
        cyc("s6_c5", 4'b0011, 16'd6);
        cyc("s6_off", 4'b0001, 16'd6);
        en_i = 1'b1;
        cyc("r6_c0", 4'b1111, 16'd6);
        cyc("r6_c1", 4'b1011, 16'd6);
        cyc("r6_c2", 4'b1011, 16'd6);
        cyc("r6_c3", 4'b0011, 16'd6);
        cyc("r6_c4", 4'b0011, 16'd6);
        cyc("r6_c5", 4'b0011, 16'd6);
        en_i = 1'b0;
        cyc("r6_off", 4'b0001, 16'd6);

        // Async reset while a change is pending
        en_i = 1'b1;
        cyc("a_c0", 4'b1111, 16'd6);
        cyc("a_c1", 4'b1011, 16'd6);
        cfg(1'b1, 16'd9);
        cyc("a_pend", 4'b1010, 16'd6);
        cfg(1'b0, 16'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst", 4'b0001, 16'd2);
        #2;
        rst_i = 1'b0;
        cyc("post_c0", 4'b1111, 16'd2);
        cyc("post_c1", 4'b0011, 16'd2);
        cyc("post_c0b", 4'b1111, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
